// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: decode/execute hazard inputs and pipeline sequencing outputs.
// Optional PERF_CNT_EN adds the performance-counter outputs.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0] iRs_RegD;
   logic [4:0] iRt_RegD;
   logic       iUsesRt_RegD;
   logic       iMemRead_RegE;
   logic [4:0] iwsel_RegE;
   logic       iBranchTaken_RegE;
   logic       iICacheStall;
   logic       iDCacheStall;
   logic       oStall_PC;
   logic       oStall_RegD;
   logic       oStall_RegE;
   logic       oStall_RegM;
   logic       oBubble_RegE;
   logic       oFlush_RegD;
   logic [1:0] oState;
   logic       oTimeout;
`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] oCntLdStall;
   logic [CNT_W-1:0] oCntMemWait;
   logic [CNT_W-1:0] oCntFlush;
`endif

   modport master (
      output iRs_RegD, iRt_RegD, iUsesRt_RegD, iMemRead_RegE, iwsel_RegE,
             iBranchTaken_RegE, iICacheStall, iDCacheStall,
      input  oStall_PC, oStall_RegD, oStall_RegE, oStall_RegM, oBubble_RegE,
             oFlush_RegD, oState, oTimeout
`ifdef PERF_CNT_EN
      , input oCntLdStall, oCntMemWait, oCntFlush
`endif
   );

   modport slave (
      input  iRs_RegD, iRt_RegD, iUsesRt_RegD, iMemRead_RegE, iwsel_RegE,
             iBranchTaken_RegE, iICacheStall, iDCacheStall,
      output oStall_PC, oStall_RegD, oStall_RegE, oStall_RegM, oBubble_RegE,
             oFlush_RegD, oState, oTimeout
`ifdef PERF_CNT_EN
      , output oCntLdStall, oCntMemWait, oCntFlush
`endif
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RUN / load-use bubble / cache-miss freeze / branch squash,
// with sticky memory-wait timeout. Optional PERF_CNT_EN adds per-action event counters.
module hazard_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1023,
   parameter int unsigned CNT_W       = 32
) (
   input logic           clk,
   input logic           rst,
   hazard_ctrl_if.slave  hz
);
   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StLdStall = 2'b01,
      StMemWait = 2'b10,
      StFlush   = 2'b11
   } state_e;

   localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1) < 1 ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT_CYC);

   state_e           r_state;
   state_e           w_action;
   logic             w_lu;
   logic [WaitW-1:0] r_wait;
   logic [WaitW-1:0] w_wait_d;
   logic             r_timeout;

   assign w_lu = hz.iMemRead_RegE && (hz.iwsel_RegE != 5'd0) &&
                 ((hz.iwsel_RegE == hz.iRs_RegD) ||
                  (hz.iUsesRt_RegD && (hz.iwsel_RegE == hz.iRt_RegD)));

   always_comb begin
      w_action        = StRun;
      hz.oStall_PC    = 1'b0;
      hz.oStall_RegD  = 1'b0;
      hz.oStall_RegE  = 1'b0;
      hz.oStall_RegM  = 1'b0;
      hz.oBubble_RegE = 1'b0;
      hz.oFlush_RegD  = 1'b0;
      if (hz.iICacheStall || hz.iDCacheStall) begin
         w_action = StMemWait;
      end else if (hz.iBranchTaken_RegE) begin
         w_action = StFlush;
      end else if (w_lu) begin
         w_action = StLdStall;
      end
      // Outputs are forced quiet while reset is held, even mid-stall.
      if (!rst) begin
         unique case (w_action)
            StMemWait: begin
               hz.oStall_PC   = 1'b1;
               hz.oStall_RegD = 1'b1;
               hz.oStall_RegE = 1'b1;
               hz.oStall_RegM = 1'b1;
            end
            StFlush: begin
               hz.oFlush_RegD  = 1'b1;
               hz.oBubble_RegE = 1'b1;
            end
            StLdStall: begin
               hz.oStall_PC    = 1'b1;
               hz.oStall_RegD  = 1'b1;
               hz.oBubble_RegE = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_wait_d = '0;
      if (w_action == StMemWait) begin
         w_wait_d = (r_wait == WaitMax) ? WaitMax : r_wait + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StRun;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_action;
         r_wait  <= w_wait_d;
         if ((w_action == StMemWait) && (w_wait_d == WaitMax)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign hz.oState   = r_state;
   assign hz.oTimeout = r_timeout;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] r_cnt_ld;
   logic [CNT_W-1:0] r_cnt_mem;
   logic [CNT_W-1:0] r_cnt_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt_ld    <= '0;
         r_cnt_mem   <= '0;
         r_cnt_flush <= '0;
      end else begin
         if (w_action == StLdStall) r_cnt_ld    <= r_cnt_ld + 1'b1;
         if (w_action == StMemWait) r_cnt_mem   <= r_cnt_mem + 1'b1;
         if (w_action == StFlush)   r_cnt_flush <= r_cnt_flush + 1'b1;
      end
   end

   assign hz.oCntLdStall = r_cnt_ld;
   assign hz.oCntMemWait = r_cnt_mem;
   assign hz.oCntFlush   = r_cnt_flush;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge monitor checks.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) u_if ();

   hazard_ctrl #(
      .TIMEOUT_CYC (8),
      .CNT_W       (32)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .hz  (u_if.slave)
   );

   // ctrl = {Stall_PC, Stall_RegD, Stall_RegE, Stall_RegM, Bubble_RegE, Flush_RegD}
   typedef struct {
      int         idx;
      logic [5:0] ctrl;
      logic [1:0] st;
      logic       to;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_n  = 0;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e   = sb.pop_front();
         act = {u_if.oStall_PC, u_if.oStall_RegD, u_if.oStall_RegE, u_if.oStall_RegM,
                u_if.oBubble_RegE, u_if.oFlush_RegD};
         checks++;
         if (act !== e.ctrl) begin
            errors++;
            $display("FAIL vec%0d ctrl: got %b expected %b", e.idx, act, e.ctrl);
         end
         checks++;
         if (u_if.oState !== e.st) begin
            errors++;
            $display("FAIL vec%0d oState: got %b expected %b", e.idx, u_if.oState, e.st);
         end
         checks++;
         if (u_if.oTimeout !== e.to) begin
            errors++;
            $display("FAIL vec%0d oTimeout: got %b expected %b", e.idx, u_if.oTimeout, e.to);
         end
      end
   end

   task automatic vec(input logic r, input logic ic, input logic dc, input logic br,
                      input logic memrd, input logic [4:0] wsel, input logic [4:0] rs,
                      input logic [4:0] rt, input logic usesrt,
                      input logic [5:0] ectrl, input logic [1:0] est, input logic eto);
      exp_t e;
      @(posedge clk);
      #1;
      rst                    = r;
      u_if.iICacheStall      = ic;
      u_if.iDCacheStall      = dc;
      u_if.iBranchTaken_RegE = br;
      u_if.iMemRead_RegE     = memrd;
      u_if.iwsel_RegE        = wsel;
      u_if.iRs_RegD          = rs;
      u_if.iRt_RegD          = rt;
      u_if.iUsesRt_RegD      = usesrt;
      e.idx  = vec_n;
      e.ctrl = ectrl;
      e.st   = est;
      e.to   = eto;
      sb.push_back(e);
      vec_n++;
   endtask

   initial begin
      rst                    = 1'b1;
      u_if.iICacheStall      = 1'b1;
      u_if.iDCacheStall      = 1'b0;
      u_if.iBranchTaken_RegE = 1'b0;
      u_if.iMemRead_RegE     = 1'b0;
      u_if.iwsel_RegE        = 5'd0;
      u_if.iRs_RegD          = 5'd0;
      u_if.iRt_RegD          = 5'd0;
      u_if.iUsesRt_RegD      = 1'b0;

      //   rst ic dc br mr wsel   rs     rt     ur  ctrl       st     to
      vec(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b00, 0);  // reset holds quiet
      vec(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b00, 0);  // I-miss after release
      vec(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b10, 0);
      vec(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 6'b110010, 2'b00, 0);  // load-use on rs
      vec(0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 6'b000000, 2'b01, 0);  // E holds NOP
      vec(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b00, 0);  // $zero never stalls
      vec(0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 6'b000000, 2'b00, 0);  // rt unused
      vec(0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 6'b110010, 2'b00, 0);  // rt used
      vec(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 6'b000011, 2'b01, 0);  // branch beats lu
      vec(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b11, 0);
      // D-miss held 4 cycles with pending branch, then one FLUSH
      vec(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b00, 0);
      vec(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 0);
      vec(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 0);
      vec(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 0);
      vec(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000011, 2'b10, 0);
      vec(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b11, 0);
      // 4 I-miss then 6 D-miss back to back: one 10-cycle wait, timeout after the 8th
      vec(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b00, 0);
      for (int i = 0; i < 3; i++) begin
         vec(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 0);
      end
      for (int i = 0; i < 4; i++) begin
         vec(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 0);
      end
      vec(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 1);
      vec(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b111100, 2'b10, 1);
      vec(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b10, 1);  // sticky
      vec(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b00, 1);
      vec(1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b00, 0);  // reset mid-stall
      vec(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 6'b000000, 2'b00, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside ForwardUnit and sequences the pipeline registers.
- Decides each cycle whether the pipeline runs, inserts a load-use bubble, freezes on a cache miss, or squashes wrong-path instructions after a taken branch.
- Tracks cache-miss wait length and raises a sticky timeout error.

Parameters:
- TIMEOUT_CYC, 1023: consecutive memory-stall cycles before oTimeout sets.
- CNT_W, 32: width of the optional performance counters.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
iRs_RegD  in  5  rs field of instruction in D
iRt_RegD  in  5  rt field of instruction in D
iUsesRt_RegD  in  1  instruction in D reads rt as a source
iMemRead_RegE  in  1  instruction in E is a load
iwsel_RegE  in  5  destination register of instruction in E
iBranchTaken_RegE  in  1  branch/jump resolved taken in E
iICacheStall  in  1  I-cache miss pending
iDCacheStall  in  1  D-cache miss pending
oStall_PC  out  1  hold PC
oStall_RegD  out  1  hold IF/ID
oStall_RegE  out  1  hold ID/EX
oStall_RegM  out  1  hold EX/MEM and MEM/WB
oBubble_RegE  out  1  load NOP into ID/EX
oFlush_RegD  out  1  load NOP into IF/ID
oState  out  2  registered action: 00 RUN, 01 LDSTALL, 10 MEMWAIT, 11 FLUSH
oTimeout  out  1  sticky memory-wait timeout

Behaviour:
- Reset (async, rst=1): state RUN, oState=00, wait counter 0, oTimeout=0. While rst=1, all stall, bubble and flush outputs are 0.
- Control outputs are combinational from the current inputs. The action chosen each cycle is registered into the state and oState on the rising edge, so oState lags the action by 1 cycle.
- Load-use hazard (lu): iMemRead_RegE & iwsel_RegE!=0 & (iwsel_RegE==iRs_RegD | (iUsesRt_RegD & iwsel_RegE==iRt_RegD)).
- Action priority, evaluated each cycle:
  - 1. MEMWAIT: iICacheStall | iDCacheStall. Assert all four oStall_*; oBubble_RegE=0, oFlush_RegD=0. The whole pipeline freezes; a pending branch or load-use is held and re-evaluated on the release cycle.
  - 2. FLUSH: iBranchTaken_RegE. Assert oFlush_RegD=1 and oBubble_RegE=1; no stalls. Branch beats lu because the dependent instruction is wrong-path.
  - 3. LDSTALL: lu. Assert oStall_PC=1, oStall_RegD=1, oBubble_RegE=1; oStall_RegE=0, oStall_RegM=0. Exactly 1 bubble per load-use: the next cycle E holds the NOP, lu evaluates false, and ForwardUnit supplies the load data from M.
  - 4. RUN: all outputs 0.
- Wait counter:
  - Increments each cycle the action is MEMWAIT and saturates at TIMEOUT_CYC.
  - Cleared on any non-MEMWAIT cycle.
  - oTimeout sets on the edge where the counter reaches TIMEOUT_CYC and stays set until rst.
- Back-to-back cache misses (I then D) with no gap count as one continuous wait.
- A cache-stall release on the same cycle as a pending branch: FLUSH is taken that cycle.
- Reset asserted mid-stall: outputs drop to 0 immediately and all state clears. The integrator must reset the datapath registers on the same rst.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined, adds outputs oCntLdStall, oCntMemWait, oCntFlush (each CNT_W bits), zeroed on rst.
- Each counter increments on every cycle whose action is LDSTALL, MEMWAIT or FLUSH respectively, and wraps modulo 2^CNT_W.
- When not defined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 with iICacheStall=1 -> all control outputs 0, oState=00, oTimeout=0; release rst, next edge -> oState=10.
- Load-use: E=lw with iwsel_RegE=5, D rs=5 -> cycle 1: oStall_PC=1, oStall_RegD=1, oBubble_RegE=1; cycle 2 (E=NOP) -> all 0. Same hazard with rs=0 and iwsel_RegE=0 -> no stall.
- rt case: iwsel_RegE=7, iRt_RegD=7, iUsesRt_RegD=0 -> no stall; with iUsesRt_RegD=1 -> LDSTALL.
- Branch vs load-use: iBranchTaken_RegE=1 and lu true in the same cycle -> oFlush_RegD=1, oBubble_RegE=1, oStall_PC=0, next oState=11.
- D-cache miss held for 4 cycles together with a taken branch -> 4 cycles with all oStall_*=1 and oFlush_RegD=0, then 1 FLUSH cycle. With PERF_CNT_EN defined: oCntMemWait=4, oCntFlush=1.
- Timeout: TIMEOUT_CYC=8, iDCacheStall held for 10 cycles -> oTimeout rises after the 8th stall cycle and stays 1 after the stall drops, until rst.
